// File: rtl/cache_line_write_buffer.sv
// Dirty-line write buffer: circular queue of evicted lines drained to the AXI line bridge,
// with combinational read-lookup forwarding. Optional same-line coalescing: WB_COALESCE_EN.
module cache_line_write_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 4,
  parameter int LINE_OFF_W = $clog2(LINE_WORDS*4)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_addr,
  input  logic [LINE_WORDS*32-1:0] push_data,
  input  logic [31:0]              lookup_addr,
  output logic                     lookup_hit,
  output logic [LINE_WORDS*32-1:0] lookup_data,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  output logic [LINE_WORDS*32-1:0] wr_data,
  input  logic                     wr_rdy,
  input  logic                     wr_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int LW    = LINE_WORDS*32;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int TAG_W = 32 - LINE_OFF_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            valid_reg [DEPTH];
  logic [TAG_W-1:0] tag_reg  [DEPTH];
  logic [LW-1:0]   data_reg  [DEPTH];
  logic [31:0]     wr_addr_reg;
  logic [LW-1:0]   wr_data_reg;

  logic [TAG_W-1:0] push_tag, lookup_tag;
  logic            coal_hit;
  logic [PW-1:0]   coal_idx;
  logic            push_fire, alloc, pop;
  logic [PW-1:0]   wr_idx;
  logic            latch;
  logic [PW-1:0]   latch_idx;
  logic            latch_fwd;
  logic [TAG_W-1:0] latch_tag;
  logic [LW-1:0]   latch_data;
  logic            unused_addr_bits;

  assign push_tag   = push_addr[31:LINE_OFF_W];
  assign lookup_tag = lookup_addr[31:LINE_OFF_W];
  assign unused_addr_bits = ^{push_addr[LINE_OFF_W-1:0], lookup_addr[LINE_OFF_W-1:0]};

`ifdef WB_COALESCE_EN
  logic in_flight;
  assign in_flight = (state_reg != IDLE);

  // Youngest matching entry wins; the head is excluded only while it is being written out.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_reg[head_reg + PW'(i)] && tag_reg[head_reg + PW'(i)] == push_tag &&
          !(in_flight && i == 0)) begin
        coal_hit = 1'b1;
        coal_idx = head_reg + PW'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign push_ready = (count_reg < CW'(DEPTH)) | coal_hit;
  assign push_fire  = push_valid & push_ready;
  assign alloc      = push_fire & ~coal_hit;
  assign wr_idx     = coal_hit ? coal_idx : tail_reg;
  assign pop        = (state_reg == WAIT) & wr_valid;
  assign count_next = count_reg + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    latch_idx  = head_reg;
    wr_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = REQ;
          latch      = 1'b1;
        end
      end
      REQ: begin
        wr_req = 1'b1;
        if (wr_rdy) state_next = WAIT;
      end
      WAIT: begin
        if (wr_valid) begin
          if (count_next != '0) begin
            state_next = REQ;
            latch      = 1'b1;
            latch_idx  = head_reg + PW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A same-cycle write into the entry being latched must be seen by the bridge.
  assign latch_fwd  = push_fire && (wr_idx == latch_idx);
  assign latch_tag  = latch_fwd ? push_tag  : tag_reg[latch_idx];
  assign latch_data = latch_fwd ? push_data : data_reg[latch_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (pop)   head_reg <= head_reg + PW'(1);
      if (alloc) tail_reg <= tail_reg + PW'(1);
      if (latch) begin
        wr_addr_reg <= {latch_tag, {LINE_OFF_W{1'b0}}};
        wr_data_reg <= latch_data;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (alloc && tail_reg == PW'(gi)) begin
        valid_reg[gi] <= 1'b1;
      end else if (pop && head_reg == PW'(gi)) begin
        valid_reg[gi] <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (push_fire && wr_idx == PW'(gi)) begin
        tag_reg[gi]  <= push_tag;
        data_reg[gi] <= push_data;
      end
    end
  end

  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_reg[head_reg + PW'(i)] && tag_reg[head_reg + PW'(i)] == lookup_tag) begin
        lookup_hit  = 1'b1;
        lookup_data = data_reg[head_reg + PW'(i)];
      end
    end
  end

  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign count   = count_reg;
  assign empty   = (count_reg == '0);

endmodule

// File: tb/tb_cache_line_write_buffer.sv
// Scoreboard bench for cache_line_write_buffer: expected drained lines are queued at push
// time and compared at each wr_req/wr_rdy handshake. Honours WB_COALESCE_EN.
module tb_cache_line_write_buffer;

  localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
  localparam int COAL_CNT = 2;
`else
  localparam int COAL_CNT = 3;
`endif

  logic         clk, rst;
  logic         push_valid, push_ready;
  logic [31:0]  push_addr, lookup_addr, wr_addr;
  logic [127:0] push_data, lookup_data, wr_data;
  logic         lookup_hit, wr_req, wr_rdy, wr_valid, empty;
  logic [2:0]   count;

  cache_line_write_buffer #(.LINE_WORDS(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mcount = 0;
  bit   m_wait = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] s);
    return {s ^ 32'hA5A5_0003, s ^ 32'h5A5A_0002, s + 32'h1111_0001, s};
  endfunction

  // One clock: score any handshake about to happen, then advance the occupancy model.
  task automatic tick();
    bit   hs;
    bit   pop_now;
    ent_t e;
    hs = 0;
    if (!rst && wr_req && wr_rdy) begin
      hs = 1;
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("drain_addr", wr_addr, e.addr);
        check("drain_data", wr_data, e.data);
      end
    end
    pop_now = !rst && wr_valid && m_wait;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      mcount = 0;
      m_wait = 0;
    end else begin
      if (pop_now) begin
        mcount--;
        m_wait = 0;
      end
      if (hs) m_wait = 1;
    end
  endtask

  task automatic do_push(input logic [31:0] addr, input logic [127:0] data, input bit coal);
    logic [31:0] masked;
    bit          exp_coal;
    bit          exp_ready;
    ent_t        e;
    masked   = addr & 32'hFFFF_FFF0;
    exp_coal = 0;
`ifdef WB_COALESCE_EN
    if (coal) foreach (sb[i]) if (sb[i].addr == masked) exp_coal = 1;
`endif
    exp_ready  = (mcount < DEPTH) || exp_coal;
    push_valid = 1'b1;
    push_addr  = addr;
    push_data  = data;
    check("push_ready", push_ready, exp_ready);
    tick();
    push_valid = 1'b0;
    if (exp_ready) begin
      if (exp_coal) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].addr == masked && exp_coal) begin
            sb[i].data = data;
            exp_coal = 0;
          end
        end
      end else begin
        e.addr = masked;
        e.data = data;
        sb.push_back(e);
        mcount++;
      end
    end
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    wr_rdy = 1'b1;
    while (mcount != 0 && n < 200) begin
      wr_valid = m_wait;
      tick();
      n++;
    end
    wr_valid = 1'b0;
    check("drain_in_time", n < 200, 1);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_sb_left", sb.size(), 0);
  endtask

  task automatic wait_inflight(input string tag);
    for (int k = 0; k < 10 && !m_wait; k++) tick();
    check(tag, m_wait, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push_valid = 0; push_addr = 0; push_data = 0;
    lookup_addr = 0; wr_rdy = 0; wr_valid = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_push_ready", push_ready, 1);
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Single line, minimum latency.
    wr_rdy = 1'b1;
    do_push(32'h0000_1040, mk(32'hA), 0);
    check("lat_n1_wr_req", wr_req, 0);
    check("lat_n1_count", count, 1);
    tick();
    check("lat_n2_wr_req", wr_req, 1);
    check("lat_n2_wr_addr", wr_addr, 32'h0000_1040);
    check("lat_n2_wr_data", wr_data, mk(32'hA));
    tick();
    check("wait_wr_req", wr_req, 0);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("single_count", count, 0);
    check("single_empty", empty, 1);

    // Fill to capacity with the bridge stalled; fifth push is refused.
    wr_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) do_push(32'h100 * i, mk(32'h100 * i), 0);
    check("full_count", count, 4);
    check("full_push_ready", push_ready, 0);
    do_push(32'h500, mk(32'h500), 0);
    check("refused_count", count, 4);
    check("stall_wr_req", wr_req, 1);
    check("stall_wr_addr", wr_addr, 32'h100);
    drain_all();

    // Lookup forwarding.
    wr_rdy = 1'b0;
    do_push(32'h2000, mk(32'hB), 0);
    lookup_addr = 32'h2008; #1;
    check("lookup_hit", lookup_hit, 1);
    check("lookup_data", lookup_data, mk(32'hB));
    lookup_addr = 32'h2010; #1;
    check("lookup_miss_hit", lookup_hit, 0);
    check("lookup_miss_data", lookup_data, 0);
    drain_all();

    // Same-line pushes behind an in-flight head.
    wr_rdy = 1'b1;
    do_push(32'h3000, mk(32'hC1), 0);
    wait_inflight("coal_head_inflight");
    wr_rdy = 1'b0;
    do_push(32'h5000, mk(32'hD), 0);
    do_push(32'h5000, mk(32'hD2), 1);
    check("coal_count", count, COAL_CNT);
    lookup_addr = 32'h5004; #1;
    check("coal_lookup_hit", lookup_hit, 1);
    check("coal_lookup_data", lookup_data, mk(32'hD2));
    drain_all();

    // Reset while waiting on the write response.
    wr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) do_push(32'h7000 + 32'h10 * i, mk(32'h70 + i), 0);
    wait_inflight("rst_wait_inflight");
    wr_rdy = 1'b0;
    check("pre_rst_count", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_wr_req", wr_req, 0);
    check("post_rst_count", count, 0);
    check("post_rst_empty", empty, 1);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("stray_valid_count", count, 0);
    tick();
    check("stray_valid_wr_req", wr_req, 0);

    // Full buffer: pop and push in the same cycle refuses the push.
    wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) do_push(32'h6003 + 32'h10 * i, mk(32'h60 + i), 0);
    wait_inflight("full_pop_inflight");
    wr_rdy = 1'b0;
    check("fp_full_count", count, 4);
    wr_valid = 1'b1;
    do_push(32'h6043, mk(32'h64), 0);
    wr_valid = 1'b0;
    check("fp_after_pop_count", count, 3);
    check("fp_push_ready", push_ready, 1);
    do_push(32'h6043, mk(32'h64), 0);
    check("fp_refill_count", count, 4);
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_line_write_buffer.md
Name: cache_line_write_buffer

Overview:
- Parametrised dirty-line write buffer between the data cache and the AXI line bridge.
- Generalises the fixed 128-bit, single-outstanding line-write channel to a configurable line width and queue depth.
- Adds read-lookup forwarding and optional same-line coalescing.
- Lets the data cache retire an evicted dirty line in one cycle and continue the refill while the writeback drains in the background.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16
DEPTH, 4, buffer entries; power of two, 2..8
LINE_OFF_W, $clog2(LINE_WORDS*4), byte-offset bits; derived, not overridden

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
push_valid  in  1  cache presents an evicted dirty line
push_ready  out  1  buffer can accept a push this cycle
push_addr  in  32  line address; bits [LINE_OFF_W-1:0] ignored
push_data  in  LINE_WORDS*32  line data, word 0 in bits [31:0]
lookup_addr  in  32  refill/read address probed against the buffer
lookup_hit  out  1  combinational: a buffered line matches lookup_addr
lookup_data  out  LINE_WORDS*32  data of the matching line; 0 when no hit
wr_req  out  1  AXI-side line write request
wr_addr  out  32  head line address, low LINE_OFF_W bits forced to 0
wr_data  out  LINE_WORDS*32  head line data
wr_rdy  in  1  AXI side accepts the request
wr_valid  in  1  AXI side reports the write is complete
count  out  $clog2(DEPTH)+1  number of occupied entries
empty  out  1  count==0

Behaviour:
- Reset: clk and rst, synchronous active-high (already decided).
- On rst, the following are 0: count, head/tail pointers, valid bits, wr_req, wr_addr, wr_data. empty=1. push_ready=1. The FSM enters IDLE.
- A reset during REQ or WAIT abandons the in-flight line. wr_req is 0 in the cycle after the reset edge. A wr_valid arriving after reset is ignored.
- Storage is a circular queue of DEPTH entries {valid, line_addr[31:LINE_OFF_W], data}. head and tail wrap modulo DEPTH.
- Push handshake: a push is accepted when push_valid && push_ready at the clock edge. push_ready = (count < DEPTH), computed from the registered count only.
- A push while full is refused even if the head pops in the same cycle.
- An accepted push writes the entry at tail, then tail+1 and count+1.
- Drain FSM:
  - IDLE: if !empty, go to REQ next cycle. The head entry is latched into wr_addr/wr_data.
  - REQ: wr_req=1. wr_addr/wr_data are held stable until wr_rdy. On wr_rdy, go to WAIT and drop wr_req in the next cycle.
  - WAIT: wr_req=0. On wr_valid, pop the head (valid=0, head+1, count-1).
    - If count_after_pop>0, go directly to REQ with the new head latched.
    - Otherwise go to IDLE.
  - wr_valid outside WAIT is ignored.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Minimum latency: push at cycle N gives wr_req=1 at cycle N+2 (IDLE→REQ latch).
- Lookup:
  - Compares lookup_addr[31:LINE_OFF_W] against every valid entry, including the in-flight head.
  - With multiple matches, the youngest entry (closest to tail) wins.
  - Purely combinational; reflects state before the current cycle's push/pop.
  - The cache must read lookup_data instead of memory on a hit.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined:
  - A push whose line address matches a valid entry that is not the in-flight head (REQ/WAIT) overwrites that entry's data in place.
  - count and tail are unchanged, and push_ready stays 1 for this push even when full.
  - A match on the in-flight head allocates a new entry normally.
- Undefined: every accepted push allocates a new entry; duplicate line addresses may coexist, and lookup returns the youngest.

Test Plan:
- Reset then idle → count=0, empty=1, push_ready=1, wr_req=0. Push {0x0000_1040, data A}, wr_rdy held 1 → wr_req=1 two cycles later with wr_addr=0x0000_1040, wr_data=A. wr_valid in WAIT → count=0, empty=1.
- Push 4 distinct lines (DEPTH=4) with wr_rdy=0 → count=4, push_ready=0. A fifth push is refused. Lines drain in push order 0x100, 0x200, 0x300, 0x400 as wr_rdy/wr_valid pulse.
- Queue 0x2000 (data B) with wr_rdy=0; lookup_addr=0x2008 → lookup_hit=1, lookup_data=B. lookup_addr=0x2010 → hit=0, data=0.
- With WB_COALESCE_EN: push 0x3000/C1 then 0x5000/D while the head is in flight, then 0x5000/D2 → count stays 2 and the drained data for 0x5000 is D2. Without the macro: count=3, and 0x5000 is drained twice (D, then D2).
- Assert rst while in WAIT with 3 entries → next cycle wr_req=0, count=0. A later stray wr_valid leaves count=0.
- Full buffer, wr_valid pop and push_valid in the same cycle → push refused. The next cycle push_ready=1 and the push is accepted, giving count=4.
